// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory bus between the IF fetch port and the
// MEM load/store port. Latches the winning request onto registered bus
// outputs, waits for i_bus_ack (or a watchdog timeout), then returns data and
// pulses the winner's valid. Stalls are combinational from req and valid.
// Optional macro MEM_ARB_RR_EN: round-robin arbitration instead of fixed
// MEM-over-IF priority.
//
// state    | meaning
// IDLE     | no access on the bus, arbitrating eligible requests
// BUSY_IF  | fetch access outstanding on the bus
// BUSY_MEM | load/store access outstanding on the bus
module mem_port_arbiter #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_if_req,
    input  logic [ADDR_WIDTH-1:0] i_if_addr,
    output logic                  o_if_valid,
    output logic [DATA_WIDTH-1:0] o_if_rdata,
    output logic                  o_stall_if,
    input  logic                  i_mem_req,
    input  logic                  i_mem_we,
    input  logic [ADDR_WIDTH-1:0] i_mem_addr,
    input  logic [DATA_WIDTH-1:0] i_mem_wdata,
    input  logic [3:0]            i_mem_be,
    output logic                  o_mem_valid,
    output logic [DATA_WIDTH-1:0] o_mem_rdata,
    output logic                  o_stall_mem,
    output logic                  o_bus_req,
    output logic                  o_bus_we,
    output logic [ADDR_WIDTH-1:0] o_bus_addr,
    output logic [DATA_WIDTH-1:0] o_bus_wdata,
    output logic [3:0]            o_bus_be,
    input  logic                  i_bus_ack,
    input  logic [DATA_WIDTH-1:0] i_bus_rdata,
    output logic                  o_bus_err
);

    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_MEM} state_t;

    localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYC);

    state_t                state_q, state_d;
    logic [7:0]            wdog_q, wdog_d;
    logic                  bus_req_q, bus_req_d;
    logic                  bus_we_q, bus_we_d;
    logic [ADDR_WIDTH-1:0] bus_addr_q, bus_addr_d;
    logic [DATA_WIDTH-1:0] bus_wdata_q, bus_wdata_d;
    logic [3:0]            bus_be_q, bus_be_d;
    logic                  bus_err_q, bus_err_d;
    logic                  if_valid_q, if_valid_d;
    logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
    logic                  mem_valid_q, mem_valid_d;
    logic [DATA_WIDTH-1:0] mem_rdata_q, mem_rdata_d;
    logic                  if_elig, mem_elig, grant_if, grant_mem;
`ifdef MEM_ARB_RR_EN
    logic                  last_if_q, last_if_d;
`endif

    // A requester in its valid cycle is dropping req, so it is not eligible.
    always_comb begin
        if_elig  = i_if_req & ~if_valid_q;
        mem_elig = i_mem_req & ~mem_valid_q;
`ifdef MEM_ARB_RR_EN
        grant_mem = mem_elig & (~if_elig | last_if_q);
`else
        grant_mem = mem_elig;
`endif
        grant_if = if_elig & ~grant_mem;
    end

    // Next-state, bus capture, watchdog and completion logic.
    always_comb begin
        state_d     = state_q;
        wdog_d      = wdog_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_be_d    = bus_be_q;
        bus_err_d   = 1'b0;
        if_valid_d  = 1'b0;
        if_rdata_d  = if_rdata_q;
        mem_valid_d = 1'b0;
        mem_rdata_d = mem_rdata_q;
`ifdef MEM_ARB_RR_EN
        last_if_d   = last_if_q;
`endif
        case (state_q)
            IDLE: begin
                wdog_d = 8'd0;
                if (grant_mem) begin
                    state_d     = BUSY_MEM;
                    bus_req_d   = 1'b1;
                    bus_we_d    = i_mem_we;
                    bus_addr_d  = i_mem_addr;
                    bus_wdata_d = i_mem_wdata;
                    bus_be_d    = i_mem_be;
`ifdef MEM_ARB_RR_EN
                    last_if_d   = 1'b0;
`endif
                end else if (grant_if) begin
                    state_d     = BUSY_IF;
                    bus_req_d   = 1'b1;
                    bus_we_d    = 1'b0;
                    bus_addr_d  = i_if_addr;
                    bus_wdata_d = '0;
                    bus_be_d    = 4'hF;
`ifdef MEM_ARB_RR_EN
                    last_if_d   = 1'b1;
`endif
                end
            end
            BUSY_IF, BUSY_MEM: begin
                if (i_bus_ack) begin
                    state_d   = IDLE;
                    bus_req_d = 1'b0;
                    wdog_d    = 8'd0;
                    if (state_q == BUSY_IF) begin
                        if_valid_d = 1'b1;
                        if_rdata_d = i_bus_rdata;
                    end else begin
                        mem_valid_d = 1'b1;
                        mem_rdata_d = bus_we_q ? '0 : i_bus_rdata;
                    end
                end else if (wdog_q + 8'd1 == TIMEOUT_LIM) begin
                    // Memory never answered: abort and hand back zero data.
                    state_d   = IDLE;
                    bus_req_d = 1'b0;
                    bus_err_d = 1'b1;
                    wdog_d    = 8'd0;
                    if (state_q == BUSY_IF) begin
                        if_valid_d = 1'b1;
                        if_rdata_d = '0;
                    end else begin
                        mem_valid_d = 1'b1;
                        mem_rdata_d = '0;
                    end
                end else begin
                    wdog_d = wdog_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; reset drops the bus request immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            wdog_q      <= 8'd0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_be_q    <= 4'h0;
            bus_err_q   <= 1'b0;
            if_valid_q  <= 1'b0;
            if_rdata_q  <= '0;
            mem_valid_q <= 1'b0;
            mem_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            wdog_q      <= wdog_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_be_q    <= bus_be_d;
            bus_err_q   <= bus_err_d;
            if_valid_q  <= if_valid_d;
            if_rdata_q  <= if_rdata_d;
            mem_valid_q <= mem_valid_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

`ifdef MEM_ARB_RR_EN
    // Round-robin pointer; reset value means IF was granted last.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_if_q <= 1'b1;
        end else begin
            last_if_q <= last_if_d;
        end
    end
`endif

    assign o_bus_req   = bus_req_q;
    assign o_bus_we    = bus_we_q;
    assign o_bus_addr  = bus_addr_q;
    assign o_bus_wdata = bus_wdata_q;
    assign o_bus_be    = bus_be_q;
    assign o_bus_err   = bus_err_q;
    assign o_if_valid  = if_valid_q;
    assign o_if_rdata  = if_rdata_q;
    assign o_mem_valid = mem_valid_q;
    assign o_mem_rdata = mem_rdata_q;
    assign o_stall_if  = i_if_req & ~if_valid_q;
    assign o_stall_mem = i_mem_req & ~mem_valid_q;

endmodule
